// File: rtl/fmc_pkg.sv
// Shared definitions for the FMC bridge / math engine BRAM arbitration.
// Default geometry and the per-BRAM owner encoding.
package fmc_pkg;

   localparam int BRAMS   = 9;
   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int CTL_IDX = BRAMS - 1;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      FMC  = 2'd1,
      MTX  = 2'd2
   } owner_e;

endpackage

// File: rtl/bram_arb_slot.sv
// One BRAM port: owner FSM (FREE/FMC/MTX) and the port mux for that BRAM.
// With MTX_ENABLE=0 the slot can never be locked by the math engine.
module bram_arb_slot #(
   parameter int AW         = 12,
   parameter int DW         = 32,
   parameter bit MTX_ENABLE = 1'b1
) (
   input  logic          fmc_clk,
   input  logic          rst,
   input  logic          fmc_en,
   input  logic          fmc_we,
   input  logic [AW-1:0] fmc_a,
   input  logic [DW-1:0] fmc_do,
   output logic [DW-1:0] fmc_di,
   input  logic          mtx_req,
   output logic          mtx_gnt,
   input  logic          mtx_en,
   input  logic          mtx_we,
   input  logic [AW-1:0] mtx_a,
   input  logic [DW-1:0] mtx_do,
   output logic [DW-1:0] mtx_di,
   output logic          bram_en,
   output logic          bram_we,
   output logic [AW-1:0] bram_a,
   output logic [DW-1:0] bram_do,
   input  logic [DW-1:0] bram_di,
   output logic          collision
);
   import fmc_pkg::*;

   owner_e owner_r;
   logic   gnt_r;
   logic   fmc_en_prev_r;

   // Owner FSM; the grant is registered together with the owner so it is never combinational from mtx_req.
   always_ff @(posedge fmc_clk) begin
      if (rst) begin
         owner_r       <= FREE;
         gnt_r         <= 1'b0;
         fmc_en_prev_r <= 1'b0;
      end else begin
         fmc_en_prev_r <= fmc_en;
         case (owner_r)
            FREE: begin
               if (fmc_en) begin
                  owner_r <= FMC;
                  gnt_r   <= 1'b0;
               end else if (mtx_req && MTX_ENABLE) begin
                  owner_r <= MTX;
                  gnt_r   <= 1'b1;
               end else begin
                  owner_r <= FREE;
                  gnt_r   <= 1'b0;
               end
            end
            FMC: begin
               // Release first; a pending lock request is picked up from FREE next edge.
               owner_r <= fmc_en ? FMC : FREE;
               gnt_r   <= 1'b0;
            end
            MTX: begin
               owner_r <= mtx_req ? MTX : FREE;
               gnt_r   <= mtx_req;
            end
            default: begin
               owner_r <= FREE;
               gnt_r   <= 1'b0;
            end
         endcase
      end
   end

   // Port mux driven from the registered owner; FMC path adds no latency.
   always_comb begin
      bram_en   = fmc_en;
      bram_we   = fmc_we & fmc_en;
      bram_a    = fmc_a;
      bram_do   = fmc_do;
      fmc_di    = bram_di;
      mtx_di    = {DW{1'b0}};
      collision = 1'b0;
      case (owner_r)
         MTX: begin
            bram_en   = mtx_en;
            bram_we   = mtx_we;
            bram_a    = mtx_a;
            bram_do   = mtx_do;
            fmc_di    = {DW{1'b0}};
            mtx_di    = bram_di;
            collision = fmc_en & ~fmc_en_prev_r;
         end
         FREE, FMC: begin
            bram_en = fmc_en;
         end
         default: begin
            bram_en = fmc_en;
         end
      endcase
   end

   assign mtx_gnt = gnt_r;

endmodule

// File: rtl/bram_arbiter.sv
// Per-BRAM arbiter between the FMC bridge and the matrix math engine.
// One slot per BRAM; the last line (control registers) stays FMC-owned.
module bram_arbiter #(
   parameter int BRAMS = fmc_pkg::BRAMS,
   parameter int AW    = fmc_pkg::AW,
   parameter int DW    = fmc_pkg::DW
) (
   input  logic                fmc_clk,
   input  logic                rst,
   input  logic [BRAMS-1:0]    fmc_en,
   input  logic                fmc_we,
   input  logic [AW-1:0]       fmc_a,
   input  logic [DW-1:0]       fmc_do,
   output logic [BRAMS*DW-1:0] fmc_di,
   input  logic [BRAMS-1:0]    mtx_req,
   output logic [BRAMS-1:0]    mtx_gnt,
   input  logic [BRAMS-1:0]    mtx_en,
   input  logic [BRAMS-1:0]    mtx_we,
   input  logic [BRAMS*AW-1:0] mtx_a,
   input  logic [BRAMS*DW-1:0] mtx_do,
   output logic [BRAMS*DW-1:0] mtx_di,
   output logic [BRAMS-1:0]    bram_en,
   output logic [BRAMS-1:0]    bram_we,
   output logic [BRAMS*AW-1:0] bram_a,
   output logic [BRAMS*DW-1:0] bram_do,
   input  logic [BRAMS*DW-1:0] bram_di,
   output logic                arb_err
);
   import fmc_pkg::*;

   localparam int CTL_LINE = BRAMS - 1;

   logic [BRAMS-1:0] collision_s;
   logic             arb_err_r;

   for (genvar i = 0; i < BRAMS; i++) begin : g_slot
      bram_arb_slot #(
         .AW         (AW),
         .DW         (DW),
         .MTX_ENABLE (i != CTL_LINE)
      ) u_slot (
         .fmc_clk   (fmc_clk),
         .rst       (rst),
         .fmc_en    (fmc_en[i]),
         .fmc_we    (fmc_we),
         .fmc_a     (fmc_a),
         .fmc_do    (fmc_do),
         .fmc_di    (fmc_di[i*DW +: DW]),
         .mtx_req   (mtx_req[i]),
         .mtx_gnt   (mtx_gnt[i]),
         .mtx_en    (mtx_en[i]),
         .mtx_we    (mtx_we[i]),
         .mtx_a     (mtx_a[i*AW +: AW]),
         .mtx_do    (mtx_do[i*DW +: DW]),
         .mtx_di    (mtx_di[i*DW +: DW]),
         .bram_en   (bram_en[i]),
         .bram_we   (bram_we[i]),
         .bram_a    (bram_a[i*AW +: AW]),
         .bram_do   (bram_do[i*DW +: DW]),
         .bram_di   (bram_di[i*DW +: DW]),
         .collision (collision_s[i])
      );
   end

   // Any slot collision gives a single one-cycle error pulse.
   always_ff @(posedge fmc_clk) begin
      if (rst) begin
         arb_err_r <= 1'b0;
      end else begin
         arb_err_r <= |collision_s;
      end
   end

   assign arb_err = arb_err_r;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed scenarios plus randomized traffic checked against a per-slot
// ownership model derived from the arbitration rules.
module tb_bram_arbiter;
   localparam int NB  = fmc_pkg::BRAMS;
   localparam int AW  = fmc_pkg::AW;
   localparam int DW  = fmc_pkg::DW;
   localparam int CTL = NB - 1;
   localparam int WMAX = NB * DW;

   logic                fmc_clk = 1'b0;
   logic                rst;
   logic [NB-1:0]       fmc_en;
   logic                fmc_we;
   logic [AW-1:0]       fmc_a;
   logic [DW-1:0]       fmc_do;
   logic [NB*DW-1:0]    fmc_di;
   logic [NB-1:0]       mtx_req, mtx_gnt, mtx_en, mtx_we;
   logic [NB*AW-1:0]    mtx_a;
   logic [NB*DW-1:0]    mtx_do, mtx_di;
   logic [NB-1:0]       bram_en, bram_we;
   logic [NB*AW-1:0]    bram_a;
   logic [NB*DW-1:0]    bram_do, bram_di;
   logic                arb_err;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: 0 = nobody, 1 = bridge, 2 = math
   int own_m  [NB];
   bit prev_m [NB];
   bit err_m;

   always #5 fmc_clk = ~fmc_clk;

   bram_arbiter dut (
      .fmc_clk (fmc_clk), .rst (rst),
      .fmc_en (fmc_en), .fmc_we (fmc_we), .fmc_a (fmc_a), .fmc_do (fmc_do), .fmc_di (fmc_di),
      .mtx_req (mtx_req), .mtx_gnt (mtx_gnt), .mtx_en (mtx_en), .mtx_we (mtx_we),
      .mtx_a (mtx_a), .mtx_do (mtx_do), .mtx_di (mtx_di),
      .bram_en (bram_en), .bram_we (bram_we), .bram_a (bram_a), .bram_do (bram_do),
      .bram_di (bram_di), .arb_err (arb_err)
   );

   task automatic check_val(input string tag, input logic [WMAX-1:0] obs, input logic [WMAX-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; fmc_en = '0; fmc_we = 1'b0; fmc_a = '0; fmc_do = '0;
      mtx_req = '0; mtx_en = '0; mtx_we = '0; mtx_a = '0; mtx_do = '0; bram_di = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         own_m[i] = 0;
         prev_m[i] = 1'b0;
      end
      err_m = 1'b0;
   endtask

   // Compare every output with what the ownership rules say for the current inputs.
   task automatic check_model();
      logic [NB-1:0]    e_en, e_we, e_gnt;
      logic [NB*AW-1:0] e_a;
      logic [NB*DW-1:0] e_do, e_fdi, e_mdi;
      for (int i = 0; i < NB; i++) begin
         bit m;
         m = (own_m[i] == 2);
         e_gnt[i]           = m;
         e_en[i]            = m ? mtx_en[i] : fmc_en[i];
         e_we[i]            = m ? mtx_we[i] : (fmc_we & fmc_en[i]);
         e_a[i*AW +: AW]    = m ? mtx_a[i*AW +: AW] : fmc_a;
         e_do[i*DW +: DW]   = m ? mtx_do[i*DW +: DW] : fmc_do;
         e_fdi[i*DW +: DW]  = m ? '0 : bram_di[i*DW +: DW];
         e_mdi[i*DW +: DW]  = m ? bram_di[i*DW +: DW] : '0;
      end
      check_val("mtx_gnt", WMAX'(mtx_gnt), WMAX'(e_gnt));
      check_val("arb_err", WMAX'(arb_err), WMAX'(err_m));
      check_val("bram_en", WMAX'(bram_en), WMAX'(e_en));
      check_val("bram_we", WMAX'(bram_we), WMAX'(e_we));
      check_val("bram_a",  WMAX'(bram_a),  WMAX'(e_a));
      check_val("bram_do", bram_do, e_do);
      check_val("fmc_di",  fmc_di,  e_fdi);
      check_val("mtx_di",  mtx_di,  e_mdi);
   endtask

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_edge();
      bit coll;
      if (rst) begin
         model_reset();
      end else begin
         coll = 1'b0;
         for (int i = 0; i < NB; i++) begin
            if (own_m[i] == 2 && fmc_en[i] && !prev_m[i]) coll = 1'b1;
            prev_m[i] = fmc_en[i];
            if (own_m[i] == 0) begin
               if (fmc_en[i]) own_m[i] = 1;
               else if (mtx_req[i] && i != CTL) own_m[i] = 2;
            end else if (own_m[i] == 1) begin
               if (!fmc_en[i]) own_m[i] = 0;
            end else begin
               if (!mtx_req[i]) own_m[i] = 0;
            end
         end
         err_m = coll;
      end
   endtask

   // Inputs are set at the falling edge; check, then cross the rising edge.
   task automatic step();
      #1;
      check_model();
      @(posedge fmc_clk);
      model_edge();
      @(negedge fmc_clk);
   endtask

   task automatic randomize_inputs();
      logic [31:0]   r;
      logic [NB-1:0] one;
      one = 1;
      r = $urandom;
      if (r[1:0] == 2'd0) fmc_en = '0;
      else if (r[3:2] == 2'd0) fmc_en = one << $urandom_range(0, NB - 1);
      for (int i = 0; i < NB; i++) begin
         if ($urandom_range(0, 7) == 0) mtx_req[i] = ~mtx_req[i];
         r = $urandom; mtx_a[i*AW +: AW] = r[AW-1:0];
         mtx_do[i*DW +: DW]  = $urandom;
         bram_di[i*DW +: DW] = $urandom;
      end
      r = $urandom; mtx_en = r[NB-1:0];
      r = $urandom; mtx_we = r[NB-1:0];
      r = $urandom; fmc_a = r[AW-1:0]; fmc_we = r[31];
      fmc_do = $urandom;
      rst = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge fmc_clk);
      @(negedge fmc_clk);
      rst = 1'b0;
      check_val("rst_gnt", WMAX'(mtx_gnt), '0);
      check_val("rst_err", WMAX'(arb_err), '0);

      // bridge read of BRAM 2
      fmc_en[2] = 1'b1; fmc_a = 12'h005; bram_di[2*DW +: DW] = 32'hDEADBEEF;
      #1;
      check_val("fmc_rd_en", WMAX'(bram_en[2]), WMAX'(1'b1));
      check_val("fmc_rd_di", WMAX'(fmc_di[2*DW +: DW]), WMAX'(32'hDEADBEEF));
      step();
      idle(); step();

      // math lock, write and release on BRAM 3
      mtx_req[3] = 1'b1; step();
      check_val("gnt3_up", WMAX'(mtx_gnt[3]), WMAX'(1'b1));
      mtx_en[3] = 1'b1; mtx_we[3] = 1'b1; mtx_a[3*AW +: AW] = 12'h010; mtx_do[3*DW +: DW] = 32'h12345678;
      #1;
      check_val("mtx_wr_we", WMAX'(bram_we[3]), WMAX'(1'b1));
      check_val("mtx_wr_a",  WMAX'(bram_a[3*AW +: AW]), WMAX'(12'h010));
      step();
      idle(); step();
      check_val("gnt3_down", WMAX'(mtx_gnt[3]), '0);

      // simultaneous request on BRAM 1: bridge wins
      mtx_req[1] = 1'b1; fmc_en[1] = 1'b1; step(); step();
      check_val("gnt1_held", WMAX'(mtx_gnt[1]), '0);
      fmc_en[1] = 1'b0; step();
      check_val("gnt1_free", WMAX'(mtx_gnt[1]), '0);
      step();
      check_val("gnt1_up", WMAX'(mtx_gnt[1]), WMAX'(1'b1));
      idle(); step();

      // collision on math-locked BRAM 4
      mtx_req[4] = 1'b1; step();
      fmc_en[4] = 1'b1; fmc_we = 1'b1; fmc_do = 32'hAAAA5555;
      mtx_en[4] = 1'b1; mtx_we[4] = 1'b1; mtx_do[4*DW +: DW] = 32'h0BADF00D;
      #1;
      check_val("coll_do", WMAX'(bram_do[4*DW +: DW]), WMAX'(32'h0BADF00D));
      check_val("coll_fdi", WMAX'(fmc_di[4*DW +: DW]), '0);
      step();
      check_val("coll_err", WMAX'(arb_err), WMAX'(1'b1));
      step();
      check_val("coll_pulse", WMAX'(arb_err), '0);
      idle(); step();

      // control line cannot be locked
      mtx_req[CTL] = 1'b1; step(); step();
      check_val("ctl_gnt", WMAX'(mtx_gnt[CTL]), '0);
      fmc_en[CTL] = 1'b1; fmc_we = 1'b1; step();
      check_val("ctl_err", WMAX'(arb_err), '0);
      idle(); step();

      // reset while math is writing BRAM 0
      mtx_req[0] = 1'b1; step();
      mtx_en[0] = 1'b1; mtx_we[0] = 1'b1; mtx_do[DW-1:0] = 32'hCAFEF00D; step();
      rst = 1'b1; step();
      rst = 1'b0;
      check_val("rst_gnt0", WMAX'(mtx_gnt[0]), '0);
      fmc_en[0] = 1'b1; fmc_do = 32'h01020304; step();
      idle(); step();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         randomize_inputs();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Per-BRAM port arbiter between the FMC-to-BRAM bridge and the matrix math engine. Each of the BRAMS single-port BRAMs is owned at any time by either the FMC bridge (default owner) or the math engine (on lock request). The arbiter muxes address, data, enable and write-enable onto the physical BRAM ports, and flags FMC accesses that hit a math-locked BRAM. The last BRAM line (math control registers) is permanently FMC-owned.

## Interface
- BRAMS, 9: number of BRAM lines; index BRAMS-1 is the control-register line.
- AW, 12: BRAM address width.
- DW, 32: data width.
- fmc_clk  in  1  the single clock; bridge, arbiter and math engine all run on it.
- rst  in  1  reset, synchronous and active-high.
- fmc_en  in  BRAMS  per-BRAM enable from the bridge.
- fmc_we  in  1  bridge write enable; applies to the enabled BRAM.
- fmc_a  in  AW  bridge address.
- fmc_do  in  DW  bridge write data.
- fmc_di  out  BRAMS*DW  read data to the bridge, slice i for BRAM i.
- mtx_req  in  BRAMS  math lock request, level.
- mtx_gnt  out  BRAMS  lock grant, registered.
- mtx_en, mtx_we  in  BRAMS each  math enable and write enable per BRAM.
- mtx_a  in  BRAMS*AW  math address per BRAM.
- mtx_do  in  BRAMS*DW  math write data per BRAM.
- mtx_di  out  BRAMS*DW  read data to math; a slice is zero unless granted.
- bram_en, bram_we  out  BRAMS each  physical BRAM enable and write enable.
- bram_a  out  BRAMS*AW  physical BRAM address.
- bram_do  out  BRAMS*DW  physical BRAM write data.
- bram_di  in  BRAMS*DW  physical BRAM read data.
- arb_err  out  1  collision pulse, registered.

## Operation
- Each BRAM slot i has a registered owner FSM with states FREE, FMC and MTX. All slots reset to FREE.
- FREE:
  - fmc_en[i]=1 → FMC. FMC wins when both requesters are active in the same cycle.
  - Otherwise, mtx_req[i]=1 → MTX.
- FMC: stays while fmc_en[i]=1. Goes to FREE on the first cycle fmc_en[i]=0; a pending mtx_req is then taken from FREE on the next edge.
- MTX: stays while mtx_req[i]=1. Goes to FREE when mtx_req[i]=0.
- Routing is combinational from the registered owner:
  - FREE/FMC: bram_en[i]=fmc_en[i], bram_we[i]=fmc_we&fmc_en[i], bram_a slice=fmc_a, bram_do slice=fmc_do, fmc_di slice=bram_di slice.
  - MTX: bram_* slices come from mtx_* slice i. fmc_di slice i is 0, and FMC writes to BRAM i are dropped.
- mtx_gnt[i] = (owner==MTX). mtx_di slice i is bram_di slice i when granted, else 0. mtx_en/mtx_we on an ungranted slot are ignored.
- Slot BRAMS-1: mtx_req is ignored, mtx_gnt[BRAMS-1]=0, and the slot is always FMC-routed.
- Collision: a rising fmc_en[i] (0 in the previous cycle, 1 now) while owner[i]==MTX sets arb_err=1 for exactly one cycle. Simultaneous collisions on several slots still produce one pulse.
- Reset mid-operation:
  - All slots go FREE and grants drop on that edge; in-flight math accesses are abandoned.
  - arb_err=0, and the previous-fmc_en register is cleared.
  - Outputs then follow the FMC inputs.

## Timing
- Reset values: owners FREE, mtx_gnt=0, arb_err=0. bram_* follow the fmc_* inputs combinationally.
- Grant latency: mtx_req[i] sampled high at edge N (fmc_en[i] low, owner FREE) → mtx_gnt[i]=1 after edge N. Math may drive mtx_en from that cycle; BRAM read data appears one cycle after its address.
- Release: mtx_req[i] sampled low at edge N → mtx_gnt[i]=0 and FMC routing after edge N.
- FMC path: zero added latency in FREE/FMC. Bridge timing is unchanged.
- arb_err: high in the cycle after the colliding fmc_en rise.
- No combinational path from mtx_req to mtx_gnt.

## Structure
- Package fmc_pkg holds:
  - owner enum (FREE/FMC/MTX);
  - default BRAMS, AW and DW;
  - CTL_IDX = BRAMS-1.
- Sub-module bram_arb_slot: one owner FSM plus the mux for one BRAM, instantiated BRAMS times in a generate loop. Slot BRAMS-1 is built with math disabled.
- The top level ORs the per-slot collision flags and registers them into arb_err.

## Test plan
- Reset, then FMC read of BRAM 2 at address 0x005 (bram_di slice = 0xDEADBEEF) → bram_en[2]=1 in the same cycle, fmc_di slice 2 = 0xDEADBEEF, mtx_gnt=0.
- mtx_req[3]=1 with FMC idle → mtx_gnt[3]=1 after one edge. Math writes 0x12345678 @0x010 → bram_we[3]=1, bram_a slice 3=0x010. Drop mtx_req → gnt 0 after one edge.
- mtx_req[1] and fmc_en[1] rise in the same cycle → owner FMC, gnt[1] stays 0 until fmc_en[1] falls, then gnt[1]=1 one edge later.
- While BRAM 4 is granted to math, FMC writes 0xAAAA5555 to it → arb_err high for one cycle, bram_do slice 4 = math data, fmc_di slice 4 = 0.
- mtx_req[8]=1 (control line) → mtx_gnt[8] stays 0; FMC access to BRAM 8 is unaffected and raises no arb_err.
- rst asserted while gnt[0]=1 and math is writing → gnt[0]=0 and bram_* follow fmc_* after the reset edge; arb_err=0.
